// File: rtl/mvm_writeback_pkg.sv
// Shared sizing defaults and state encoding for the MVM result writeback path.
// The defines mirror the header used by the MVMPU; guarded so an existing definition wins.
`ifndef MVPE_N
`define MVPE_N 4
`endif
`ifndef INTWIDTH
`define INTWIDTH 16
`endif
`ifndef VAW
`define VAW 10
`endif

package mvm_writeback_pkg;

    localparam int unsigned LenWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wb_state_e;

    // ceil(len / lanes), one bit wider than len so no overflow at len = 0xFFFF
    function automatic logic [LenWidth:0] groups_needed(input logic [LenWidth-1:0] len,
                                                        input int unsigned lanes);
        return ({1'b0, len} + (LenWidth + 1)'(lanes - 1)) / (LenWidth + 1)'(lanes);
    endfunction

endpackage

// File: rtl/mvm_writeback_if.sv
// Result-group input handshake and vector-memory write port of the writeback block.
interface mvm_writeback_if #(
    parameter int unsigned MVPE_N   = `MVPE_N,
    parameter int unsigned INTWIDTH = `INTWIDTH,
    parameter int unsigned VAW      = `VAW
);
    logic                       in_valid;
    logic [MVPE_N*INTWIDTH-1:0] in_data;
    logic                       in_ready;
    logic                       wr_en;
    logic [VAW-1:0]             wr_addr;
    logic [INTWIDTH-1:0]        wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/mvm_wb_fifo.sv
// Two-entry synchronous FIFO holding result groups waiting for the serializer.
module mvm_wb_fifo #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_en;
    logic             pop_en;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mvm_writeback.sv
// Serializes MVMPU result groups into single-element vector-memory writes,
// with optional ReLU clamping and truncation of the final partial group.
module mvm_writeback
    import mvm_writeback_pkg::*;
#(
    parameter int unsigned MVPE_N   = `MVPE_N,
    parameter int unsigned INTWIDTH = `INTWIDTH,
    parameter int unsigned VAW      = `VAW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LenWidth-1:0] len,
    input  logic [VAW-1:0]      base_addr,
    input  logic                relu_en,
    mvm_writeback_if.slave      wb,
    output logic                busy,
    output logic                done
);
    localparam int unsigned GW = MVPE_N * INTWIDTH;
    localparam int unsigned LW = (MVPE_N > 1) ? $clog2(MVPE_N) : 1;
    localparam logic [LW-1:0] LastLane = LW'(MVPE_N - 1);

    wb_state_e           state_q;
    logic                busy_q;
    logic                done_q;
    logic [LenWidth-1:0] len_q;
    logic [VAW-1:0]      base_q;
    logic                relu_q;
    logic [LenWidth:0]   groups_total_q;
    logic [LenWidth:0]   groups_acc_q;
    logic [LenWidth-1:0] elem_q;
    logic [GW-1:0]       cur_q;
    logic [LW-1:0]       lane_q;
    logic                cur_valid_q;
    logic                wr_en_q;
    logic                last_q;
    logic [VAW-1:0]      wr_addr_q;
    logic [INTWIDTH-1:0] wr_data_q;

    logic                in_ready;
    logic                accept;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [GW-1:0]       fifo_head;
    logic                src_valid;
    logic [GW-1:0]       src_group;
    logic [LW-1:0]       src_lane;
    logic [31:0]         lane_ofs;
    logic [INTWIDTH-1:0] lane_val;
    logic                last_elem;
    logic                group_end;

    assign in_ready    = (state_q == StRun) && !fifo_full && (groups_acc_q < groups_total_q);
    assign accept      = wb.in_valid && in_ready;
    assign wb.in_ready = in_ready;
    assign wb.wr_en    = wr_en_q;
    assign wb.wr_addr  = wr_addr_q;
    assign wb.wr_data  = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

    mvm_wb_fifo #(
        .WIDTH (GW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (wb.in_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Source priority: group in progress, then FIFO head, then the incoming group
    // directly, so an idle serializer writes lane 0 the cycle after acceptance.
    always_comb begin
        src_valid = 1'b0;
        src_group = cur_q;
        src_lane  = lane_q;
        fifo_pop  = 1'b0;
        if (state_q == StRun) begin
            if (cur_valid_q) begin
                src_valid = 1'b1;
            end else if (!fifo_empty) begin
                src_valid = 1'b1;
                src_group = fifo_head;
                src_lane  = '0;
                fifo_pop  = 1'b1;
            end else if (accept) begin
                src_valid = 1'b1;
                src_group = wb.in_data;
                src_lane  = '0;
            end
        end
    end

    assign fifo_push = accept && (cur_valid_q || !fifo_empty);
    assign lane_ofs  = 32'(src_lane) * INTWIDTH;
    assign lane_val  = src_group[lane_ofs +: INTWIDTH];
    assign last_elem = (elem_q == len_q - 1'b1);
    assign group_end = (src_lane == LastLane) || last_elem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q          <= '0;
            base_q         <= '0;
            relu_q         <= 1'b0;
            groups_total_q <= '0;
            groups_acc_q   <= '0;
            elem_q         <= '0;
            cur_q          <= '0;
            lane_q         <= '0;
            cur_valid_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            last_q         <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            last_q  <= 1'b0;
            if (state_q == StIdle && start) begin
                len_q          <= len;
                base_q         <= base_addr;
                relu_q         <= relu_en;
                groups_total_q <= groups_needed(len, MVPE_N);
                groups_acc_q   <= '0;
                elem_q         <= '0;
                lane_q         <= '0;
                cur_valid_q    <= 1'b0;
            end else begin
                if (accept) begin
                    groups_acc_q <= groups_acc_q + 1'b1;
                end
                if (src_valid) begin
                    wr_en_q     <= 1'b1;
                    last_q      <= last_elem;
                    wr_addr_q   <= base_q + VAW'(elem_q);
                    wr_data_q   <= (relu_q && lane_val[INTWIDTH-1]) ? '0 : lane_val;
                    elem_q      <= elem_q + 1'b1;
                    cur_q       <= src_group;
                    lane_q      <= src_lane + 1'b1;
                    cur_valid_q <= !group_end;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (wr_en_q && last_q) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_writeback.sv
// Scoreboard bench for mvm_writeback: directed corner jobs plus randomized jobs,
// expected writes derived from the element/address/ReLU rules.
module tb_mvm_writeback;
    localparam int unsigned N = 4;
    localparam int unsigned W = 16;
    localparam int unsigned A = 10;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  len = '0;
    logic [A-1:0] base_addr = '0;
    logic         relu_en = 1'b0;
    logic         busy;
    logic         done;

    mvm_writeback_if #(.MVPE_N(N), .INTWIDTH(W), .VAW(A)) wif ();

    mvm_writeback #(
        .MVPE_N   (N),
        .INTWIDTH (W),
        .VAW      (A)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .base_addr (base_addr),
        .relu_en   (relu_en),
        .wb        (wif.slave),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t                 exp_q[$];
    int                   wr_cyc[$];
    logic signed [W-1:0]  vals[$];
    int                   vectors = 0;
    int                   miscompares = 0;
    int                   n_wr = 0;
    int                   n_done = 0;
    int                   done_cyc = -1;
    int                   stalls = 0;

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT event not seen within bound at cycle %0d", name, cyc);
    endtask

    function automatic logic [N*W-1:0] grp(input int k);
        logic [N*W-1:0] r;
        for (int j = 0; j < N; j++) r[j*W +: W] = vals[k*N + j];
        return r;
    endfunction

    // Monitor: every write strobe is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wif.wr_en) begin
                wr_cyc.push_back(cyc);
                n_wr++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: actual addr 0x%0h data 0x%0h, required none",
                             wif.wr_addr, wif.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wif.wr_addr, e.addr);
                    chk("wr_data", wif.wr_data, e.data);
                end
            end
            if (rst_n && done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic offer(input logic [N*W-1:0] d, output bit ok, output int acc_cyc);
        int budget = 200;
        ok = 1'b0;
        acc_cyc = -1;
        wif.in_valid = 1'b1;
        wif.in_data  = d;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (wif.in_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end else if (busy) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            budget--;
        end
        wif.in_valid = 1'b0;
    endtask

    task automatic push_expected(input int l, input int b, input bit relu);
        exp_t e;
        logic signed [W-1:0] v;
        for (int i = 0; i < l; i++) begin
            v = vals[i];
            e.addr = A'(b + i);
            e.data = (relu && v < 0) ? '0 : v;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int l, input int b, input bit relu, output int sc);
        start     = 1'b1;
        len       = 16'(l);
        base_addr = A'(b);
        relu_en   = relu;
        @(negedge clk);
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called and returns at posedge+1.
    task automatic run_job(input int l, input int b, input bit relu, input int gap_max,
                           input bit b2b);
        int g = (l + N - 1) / N;
        int wr0 = n_wr;
        int dn0 = n_done;
        int start_cyc, acc_c, gap, budget;
        int acc0 = -1;
        bit ok, extra;
        while (vals.size() < g * N) vals.push_back(W'($urandom));
        push_expected(l, b, relu);
        pulse_start(l, b, relu, start_cyc);
        for (int k = 0; k < g; k++) begin
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            offer(grp(k), ok, acc_c);
            if (!ok) begin
                fail_now("group_accept");
                break;
            end
            if (k == 0) acc0 = acc_c;
        end
        // Keep offering a surplus group; it must never be taken.
        wif.in_valid = 1'b1;
        wif.in_data  = {(N*W){1'b1}};
        extra  = 1'b0;
        budget = 8 * l + 50;
        while (budget > 0) begin
            @(negedge clk);
            #1;
            if (wif.in_ready) extra = 1'b1;
            if (n_done != dn0) break;
            budget--;
        end
        wif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("done_pulses", n_done - dn0, 1);
        chk("surplus_group_refused", extra, 0);
        chk("write_count", n_wr - wr0, l);
        if (l == 0) begin
            chk("done_after_start", done_cyc, start_cyc + 1);
        end else if (n_wr - wr0 >= l) begin
            chk("done_after_last_write", done_cyc, wr_cyc[wr0 + l - 1] + 1);
            if (acc0 >= 0) chk("first_write_latency", wr_cyc[wr0], acc0 + 1);
            if (b2b) chk("writes_contiguous", wr_cyc[wr0 + l - 1] - wr_cyc[wr0], l - 1);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("busy_after_job", busy, 0);
        chk("done_single_cycle", done, 0);
        vals.delete();
    endtask

    task automatic reset_mid_job();
        int wr0, dn0, sc, acc_c, budget;
        bit ok;
        for (int i = 0; i < 8; i++) vals.push_back(W'($urandom));
        wr0 = n_wr;
        dn0 = n_done;
        push_expected(8, 'h2A0, 1'b0);
        pulse_start(8, 'h2A0, 1'b0, sc);
        offer(grp(0), ok, acc_c);
        if (!ok) fail_now("reset_job_accept0");
        offer(grp(1), ok, acc_c);
        if (!ok) fail_now("reset_job_accept1");
        budget = 50;
        while (n_wr - wr0 < 3 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (n_wr - wr0 < 3) fail_now("reset_job_three_writes");
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", wif.wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", wif.in_ready, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        vals.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_more_writes", n_wr - wr0, 3);
        chk("abort_no_done", n_done - dn0, 0);
    endtask

    initial begin
        wif.in_valid = 1'b0;
        wif.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", wif.in_ready, 0);
        chk("reset_wr_en", wif.wr_en, 0);
        chk("reset_wr_addr", wif.wr_addr, 0);
        chk("reset_wr_data", wif.wr_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 8; i++) vals.push_back(W'(i));
        run_job(8, 'h010, 1'b0, 0, 1'b1);

        for (int i = 1; i <= 8; i++) vals.push_back(W'(i));
        run_job(6, 'h010, 1'b0, 0, 1'b1);

        vals.push_back(-16'sd5);
        vals.push_back(16'sd3);
        vals.push_back(16'sd0);
        vals.push_back(-16'sd1);
        run_job(4, 'h123, 1'b1, 0, 1'b1);

        run_job(4, 'h3FE, 1'b0, 0, 1'b1);

        stalls = 0;
        run_job(16, $urandom_range(0, 1023), 1'b0, 0, 1'b1);
        chk("fifo_full_backpressure", (stalls > 0) ? 1 : 0, 1);

        run_job(0, 'h005, 1'b0, 0, 1'b0);

        for (int j = 0; j < 20; j++) begin
            run_job($urandom_range(1, 40), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
                    3, 1'b0);
        end

        reset_mid_job();
        run_job($urandom_range(5, 20), $urandom_range(0, 1023), 1'b1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
